window_shifter: RTL and testbench

//  Converts the KERNEL_LENGTH-row column stream from the line-buffer split stage into

---
 rtl/window_shifter.sv | 118 +++++++++++
 tb/tb_window_shifter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_shifter.sv
// Turns the K-row column stream from the line-buffer split stage into KxK stride-1
// sliding windows; the fill columns at the start of each row never produce a window.
module window_shifter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned KERNEL_LENGTH = 3,
    parameter int unsigned IMG_WIDTH     = 64
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      in_valid,
    output logic                                                      in_ready,
    input  logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]                  din,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [KERNEL_LENGTH-1:0][KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] window,
    output logic [$clog2(IMG_WIDTH)-1:0]                              out_col,
    output logic                                                      row_done
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned HW = KERNEL_LENGTH - 1;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_cnt_nxt;
    logic          acc;
    logic          emit;
    logic          last;

    // Only the K-1 most recent columns need storing; the newest comes straight from din.
    logic [KERNEL_LENGTH-1:0][HW-1:0][DATA_WIDTH-1:0]            hist;
    logic [KERNEL_LENGTH-1:0][KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] shifted_c;

    // A single output register: a new column may enter whenever the window slot frees up.
    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // Window as it looks after the incoming column is shifted in.
    always_comb begin
        shifted_c = '0;
        for (int r = 0; r < int'(KERNEL_LENGTH); r++) begin
            for (int c = 0; c < int'(HW); c++) begin
                shifted_c[r][c] = hist[r][c];
            end
            shifted_c[r][HW] = din[r];
        end
    end

    // Next state, column counter and emit decision.
    always_comb begin
        state_nxt   = state;
        col_cnt_nxt = col_cnt;
        emit        = 1'b0;
        last        = 1'b0;
        if (acc) begin
            col_cnt_nxt = (col_cnt == CW'(IMG_WIDTH - 1)) ? '0 : col_cnt + CW'(1);
            case (state)
                FILL: begin
                    if (col_cnt == CW'(KERNEL_LENGTH - 2)) begin
                        state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    emit = 1'b1;
                    if (col_cnt == CW'(IMG_WIDTH - 1)) begin
                        last      = 1'b1;
                        state_nxt = FILL;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    // State, counter and column history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FILL;
            col_cnt <= '0;
            hist    <= '0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_cnt_nxt;
            if (acc) begin
                for (int r = 0; r < int'(KERNEL_LENGTH); r++) begin
                    for (int c = 0; c < int'(HW); c++) begin
                        hist[r][c] <= shifted_c[r][c+1];
                    end
                end
            end
        end
    end

    // Output slot: loads on emit, holds under backpressure, clears after handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            window    <= '0;
            out_col   <= '0;
            row_done  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            window    <= shifted_c;
            out_col   <= col_cnt - CW'(KERNEL_LENGTH - 1);
            row_done  <= last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            row_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_shifter.sv
// Bench for window_shifter: directed start-of-row table plus scoreboard-checked
// streaming, backpressure, row-boundary, bubbly and mid-row reset sequences.
module tb_window_shifter;

    localparam int unsigned DW = 32;
    localparam int unsigned K  = 3;
    localparam int unsigned W  = 64;
    localparam int unsigned CW = 6;

    typedef logic [K*K*DW-1:0] win_t;

    typedef struct {
        win_t          win;
        logic [CW-1:0] col;
        logic          rd;
    } exp_t;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          exp_ov;
        logic          exp_ir;
        logic [CW-1:0] exp_col;
    } vec_t;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           in_valid;
    logic                           in_ready;
    logic [K-1:0][DW-1:0]           din;
    logic                           out_valid;
    logic                           out_ready;
    logic [K-1:0][K-1:0][DW-1:0]    window;
    logic [CW-1:0]                  out_col;
    logic                           row_done;

    exp_t          sbq[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            tb_row = 0;
    int            tb_col = 0;
    int            pops = 0;
    int            rd_pops = 0;
    int            idle = 0;
    bit            count_idle = 1'b0;
    bit            seen_first = 1'b0;
    logic          prev_stall = 1'b0;
    win_t          prev_win;
    logic [CW-1:0] prev_col;
    logic          prev_rd;

    always #5 clk = ~clk;

    window_shifter #(
        .DATA_WIDTH   (DW),
        .KERNEL_LENGTH(K),
        .IMG_WIDTH    (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .window   (window),
        .out_col  (out_col),
        .row_done (row_done)
    );

    function automatic logic [DW-1:0] pix(input int row, input int r, input int col);
        return DW'(row * 10000 + 100 * r + col);
    endfunction

    task automatic chk(input string name, input win_t act, input win_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive din for the current column, then check outputs away from the clock edge.
    task automatic sample();
        exp_t e;
        for (int r = 0; r < int'(K); r++) din[r] = pix(tb_row, r, tb_col);
        #2;
        if (!rst) begin
            chk("rst_out_valid", win_t'(out_valid), win_t'(1'b0));
            chk("rst_row_done", win_t'(row_done), win_t'(1'b0));
            chk("rst_in_ready", win_t'(in_ready), win_t'(1'b1));
            chk("rst_window", win_t'(window), win_t'(0));
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", win_t'(in_ready), win_t'(!out_valid || out_ready));
            if (!out_valid) chk("row_done_idle", win_t'(row_done), win_t'(1'b0));
            if (prev_stall) begin
                chk("hold_valid", win_t'(out_valid), win_t'(1'b1));
                chk("hold_window", win_t'(window), prev_win);
                chk("hold_col", win_t'(out_col), win_t'(prev_col));
                chk("hold_row_done", win_t'(row_done), win_t'(prev_rd));
            end
            if (count_idle) begin
                if (out_valid) seen_first = 1'b1;
                else if (seen_first) idle++;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_window: got window at out_col %0d, expected none", out_col);
                end else begin
                    e = sbq.pop_front();
                    chk("window", win_t'(window), e.win);
                    chk("out_col", win_t'(out_col), win_t'(e.col));
                    chk("row_done", win_t'(row_done), win_t'(e.rd));
                    pops++;
                    if (row_done) rd_pops++;
                end
            end
            if (in_valid && in_ready) begin
                if (tb_col >= int'(K) - 1) begin
                    for (int r = 0; r < int'(K); r++)
                        for (int c = 0; c < int'(K); c++)
                            e.win[(r*int'(K)+c)*int'(DW) +: DW] = pix(tb_row, r, tb_col - (int'(K) - 1) + c);
                    e.col = CW'(tb_col - (int'(K) - 1));
                    e.rd  = (tb_col == int'(W) - 1);
                    sbq.push_back(e);
                end
                if (tb_col == int'(W) - 1) begin
                    tb_col = 0;
                    tb_row++;
                end else begin
                    tb_col++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_win   = win_t'(window);
            prev_col   = out_col;
            prev_rd    = row_done;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
        step();
        chk("drain_empty", win_t'(sbq.size()), win_t'(0));
    endtask

    vec_t tbl[11];

    initial begin
        int   saved;
        int   guard;
        win_t w1;

        // Start of row 0 with a 2-cycle stall on the first window.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, CW'(0)};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, CW'(0)};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, CW'(0)};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, CW'(0)};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, CW'(0)};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, CW'(0)};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, CW'(0)};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, CW'(0)};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, CW'(1)};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, CW'(2)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, CW'(0)};

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        @(negedge clk);

        // Reset held with random handshake inputs.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = 1'($urandom_range(1, 0));
            step();
        end
        rst = 1'b1;

        // Directed start of row 0, then the rest of the row at full rate.
        pops    = 0;
        rd_pops = 0;
        for (int i = 0; i < 11; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            sample();
            chk("tbl_out_valid", win_t'(out_valid), win_t'(tbl[i].exp_ov));
            chk("tbl_in_ready", win_t'(in_ready), win_t'(tbl[i].exp_ir));
            if (tbl[i].exp_ov) chk("tbl_out_col", win_t'(out_col), win_t'(tbl[i].exp_col));
            if (i == 3) begin
                w1 = win_t'({window[1][2], window[1][1], window[1][0]});
                chk("first_window_row1", w1, win_t'({32'd102, 32'd101, 32'd100}));
            end
            advance();
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (tb_row == 0 && guard < 200) begin
            step();
            guard++;
        end
        drain();
        chk("row0_windows", win_t'(pops), win_t'(62));
        chk("row0_row_done", win_t'(rd_pops), win_t'(1));

        // Backpressure for 5 cycles in the middle of row 1.
        pops      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (tb_col < 20 && guard < 200) begin
            step();
            guard++;
        end
        saved     = tb_col;
        out_ready = 1'b0;
        repeat (5) step();
        chk("bp_no_consume", win_t'(tb_col), win_t'(saved));
        out_ready = 1'b1;
        guard = 0;
        while (tb_row == 1 && guard < 200) begin
            step();
            guard++;
        end
        drain();
        chk("row1_windows", win_t'(pops), win_t'(62));

        // Rows 2 and 3 back to back.
        pops       = 0;
        rd_pops    = 0;
        idle       = 0;
        seen_first = 1'b0;
        count_idle = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        repeat (128) step();
        count_idle = 1'b0;
        drain();
        chk("two_row_windows", win_t'(pops), win_t'(124));
        chk("two_row_row_done", win_t'(rd_pops), win_t'(2));
        chk("row_boundary_idle", win_t'(idle), win_t'(2));

        // Bubbly input with random output backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = (i % 2 == 0);
            out_ready = 1'($urandom_range(1, 0));
            step();
        end
        drain();

        // Reset in the middle of a row.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (tb_col != 30 && guard < 200) begin
            step();
            guard++;
        end
        rst = 1'b0;
        sbq.delete();
        tb_col = 0;
        tb_row++;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = 1'($urandom_range(1, 0));
            step();
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("post_rst_quiet", win_t'(out_valid), win_t'(1'b0));
            advance();
        end
        sample();
        chk("post_rst_valid", win_t'(out_valid), win_t'(1'b1));
        chk("post_rst_col", win_t'(out_col), win_t'(0));
        advance();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
